// File: rtl/regfile_pkg.sv
// Purpose: shared widths, address/data types and the x0 constant for the scoreboarded register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int NUM_REGS_DEFAULT = 32;

    typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] word_t;

    // x0 is hardwired to zero; it has no storage and no scoreboard bit.
    localparam reg_addr_t X0 = '0;

endpackage : regfile_pkg

// File: rtl/register_file_sb_if.sv
// Purpose: decode/writeback boundary bundle of the scoreboarded register file.
// Latency: wires only; reads and the issue handshake are combinational.
// Backpressure: iss_ready from the register file stalls issue on a WAW hazard.
//
// Ports: two read ports (rd_reg_* -> rd_data_*/rd_busy_*), an issue port
// (iss_valid/iss_rd -> iss_ready), a writeback port (wr_en/wr_reg/wr_data),
// plus pending_cnt and the err_unexpected_wr pulse.
// master = decode/writeback side, slave = register file.
interface register_file_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    rd_reg_1;
    logic [AW-1:0]    rd_reg_2;
    logic [XLEN-1:0]  rd_data_1;
    logic [XLEN-1:0]  rd_data_2;
    logic             rd_busy_1;
    logic             rd_busy_2;
    logic             iss_valid;
    logic [AW-1:0]    iss_rd;
    logic             iss_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_reg;
    logic [XLEN-1:0]  wr_data;
    logic [CNT_W-1:0] pending_cnt;
    logic             err_unexpected_wr;

    modport master (
        output rd_reg_1, rd_reg_2, iss_valid, iss_rd, wr_en, wr_reg, wr_data,
        input  rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, iss_ready,
               pending_cnt, err_unexpected_wr
    );

    modport slave (
        input  rd_reg_1, rd_reg_2, iss_valid, iss_rd, wr_en, wr_reg, wr_data,
        output rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, iss_ready,
               pending_cnt, err_unexpected_wr
    );

endinterface : register_file_sb_if

// File: rtl/regfile_read_port.sv
// Purpose: one combinational read port: x0 forcing, writeback bypass, storage mux, busy flag.
// Latency: zero cycles (purely combinational).
// Backpressure: none; busy tells decode the value is not yet valid.
//
// Ports: addr in; wr_en/wr_reg/wr_data bypass source; regs storage and
// pending vector from the top; data/busy out.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]                     addr,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_reg,
    input  logic [XLEN-1:0]                   wr_data,
    input  logic [NUM_REGS-1:1][XLEN-1:0]     regs,
    input  logic [NUM_REGS-1:0]               pending,
    output logic [XLEN-1:0]                   data,
    output logic                              busy
);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr == X0) begin
            data = '0;
            busy = 1'b0;
        end else if (wr_en && (wr_reg == addr)) begin
            // The commit in flight satisfies this read, so it is never busy.
            data = wr_data;
            busy = 1'b0;
        end else begin
            data = regs[addr];
            busy = pending[addr];
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file_sb.sv
// Purpose: scoreboarded 32x32 integer register file, 2 read ports + 1 write port, x0 reads zero.
// Latency: reads/bypass/issue handshake combinational; writes and pending bits visible next cycle.
// Backpressure: iss_ready drops while the issuing destination still has an outstanding write (WAW).
//
// Ports: clk, rst (async, active-high) and the slave side of register_file_sb_if
// carrying read, issue, writeback, pending_cnt and err_unexpected_wr.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    register_file_sb_if.slave  bus
);

    localparam int AW    = $clog2(NUM_REGS);
    localparam int CNT_W = AW + 1;

    logic [NUM_REGS-1:1][XLEN-1:0] regs_q;
    logic [NUM_REGS-1:0]           pending_q;
    logic [NUM_REGS-1:0]           pending_d;
    logic [CNT_W-1:0]              cnt_q;
    logic                          err_q;

    logic wr_nz;
    logic set_hit;
    logic clr_hit;

    assign wr_nz = bus.wr_en && (bus.wr_reg != X0);

    // A WAW stall only lasts while the older write is outstanding; a commit
    // to the same register this cycle releases it.
    assign bus.iss_ready = (bus.iss_rd == X0) || !pending_q[bus.iss_rd] ||
                           (bus.wr_en && (bus.wr_reg == bus.iss_rd));

    assign set_hit = bus.iss_valid && bus.iss_ready && (bus.iss_rd != X0);
    assign clr_hit = wr_nz && pending_q[bus.wr_reg];

    // Clear before set: a commit and a new issue to the same register leave
    // the bit set for the younger instruction.
    always_comb begin
        pending_d = pending_q;
        if (clr_hit) pending_d[bus.wr_reg] = 1'b0;
        if (set_hit) pending_d[bus.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (wr_nz) begin
            regs_q[bus.wr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            // Set and clear on the same register cancel; count stays bounded
            // by the number of nonzero registers.
            cnt_q     <= cnt_q + CNT_W'(set_hit) - CNT_W'(clr_hit);
            err_q     <= wr_nz && !pending_q[bus.wr_reg];
        end
    end

    assign bus.pending_cnt       = cnt_q;
    assign bus.err_unexpected_wr = err_q;

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_rd_port_1 (
        .addr    (bus.rd_reg_1),
        .wr_en   (bus.wr_en),
        .wr_reg  (bus.wr_reg),
        .wr_data (bus.wr_data),
        .regs    (regs_q),
        .pending (pending_q),
        .data    (bus.rd_data_1),
        .busy    (bus.rd_busy_1)
    );

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_rd_port_2 (
        .addr    (bus.rd_reg_2),
        .wr_en   (bus.wr_en),
        .wr_reg  (bus.wr_reg),
        .wr_data (bus.wr_data),
        .regs    (regs_q),
        .pending (pending_q),
        .data    (bus.rd_data_2),
        .busy    (bus.rd_busy_2)
    );

endmodule : register_file_sb
